// File: rtl/control_state_seq.sv
// control_state_seq: sequencer emitting the 4-bit state code S for the datapath control decoder.
// Optional single-step control is enabled by defining CTRL_SEQ_SINGLE_STEP_EN.
module control_state_seq #(
  parameter int ITER_W   = 4,
  parameter int MAX_ITER = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] n_iter,
  input  logic              stall,
  input  logic              done_ack,
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  input  logic              step,
  input  logic              step_mode,
`endif
  output logic [3:0]        S,
  output logic              busy,
  output logic [ITER_W-1:0] iter_left,
  output logic              err
);
  typedef enum logic [3:0] {
    IDLE  = 4'h0,
    LOAD  = 4'h1,
    BODY0 = 4'h2,
    BODYN = 4'hA,
    DONE  = 4'hB,
    ILL0  = 4'hC,
    ILL1  = 4'hD,
    FIN1  = 4'hE,
    FIN2  = 4'hF
  } state_t;
  localparam logic [ITER_W-1:0] MAX_C = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ONE   = ITER_W'(1);
  logic [3:0]        r_s;
  logic [ITER_W-1:0] r_iter;
  logic              r_err;
  logic              w_adv;
  logic [ITER_W-1:0] w_n;
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  assign w_adv = ~stall & (~step_mode | step);
`else
  assign w_adv = ~stall;
`endif
  // zero iterations still runs one pass
  assign w_n = n_iter == '0 ? ONE : (n_iter < MAX_C ? n_iter : MAX_C);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= IDLE;
      r_iter <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_s)
        IDLE: if (start) begin
          r_s    <= LOAD;
          r_iter <= w_n;
          r_err  <= 1'b0;
        end
        DONE: if (done_ack) r_s <= IDLE;
        ILL0, ILL1: begin
          r_s    <= IDLE;
          r_iter <= '0;
          r_err  <= 1'b1;
        end
        BODYN: if (w_adv) begin
          r_s    <= r_iter > ONE ? BODY0 : FIN1;
          r_iter <= r_iter - ONE;
        end
        FIN1: if (w_adv) r_s <= FIN2;
        FIN2: if (w_adv) r_s <= DONE;
        default: if (w_adv) r_s <= r_s + 4'd1;
      endcase
    end
  end
  assign S         = r_s;
  assign busy      = r_s != IDLE;
  assign iter_left = r_iter;
  assign err       = r_err;
endmodule

// File: tb/tb_control_state_seq.sv
// tb_control_state_seq: vector table plus scoreboarded run sequences for control_state_seq.
module tb_control_state_seq;
  typedef struct packed {
    logic       rst;
    logic       start;
    logic [3:0] n;
    logic       stall;
    logic       ack;
    logic [3:0] s;
    logic       busy;
    logic [3:0] it;
    logic       err;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst, start, stall, done_ack;
  logic [3:0] n_iter, S, iter_left, S2, it2;
  logic       busy, err, busy2, err2;
  int         n_cmp = 0, n_bad = 0, cyc = 0;
  int         t_load = 0, t_done = 0, t2_load = 0, t2_done = 0;
  logic [3:0] ps = 4'h0, ps2 = 4'h0, it2_load = 4'h0;
  string      tag = "";
  vec_t       q[$];
  vec_t       tbl[10];
  always #5 clk = ~clk;
  control_state_seq #(.ITER_W(4), .MAX_ITER(15)) dut (
    .clk(clk), .rst(rst), .start(start), .n_iter(n_iter), .stall(stall), .done_ack(done_ack),
    .S(S), .busy(busy), .iter_left(iter_left), .err(err)
  );
  control_state_seq #(.ITER_W(4), .MAX_ITER(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .n_iter(n_iter), .stall(stall), .done_ack(done_ack),
    .S(S2), .busy(busy2), .iter_left(it2), .err(err2)
  );
  function automatic vec_t mk(input logic r, input logic st, input logic [3:0] n, input logic sl,
                              input logic ak, input logic [3:0] s, input logic b,
                              input logic [3:0] it, input logic e);
    return '{r, st, n, sl, ak, s, b, it, e};
  endfunction
  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (S == 4'h1 && ps != 4'h1) t_load = cyc;
    if (S == 4'hB && ps != 4'hB) t_done = cyc;
    if (S2 == 4'h1 && ps2 != 4'h1) begin
      t2_load  = cyc;
      it2_load = it2;
    end
    if (S2 == 4'hB && ps2 != 4'hB) t2_done = cyc;
    ps  = S;
    ps2 = S2;
  endtask
  task automatic step(input vec_t v);
    vec_t e;
    rst = v.rst; start = v.start; n_iter = v.n; stall = v.stall; done_ack = v.ack;
    q.push_back(v);
    tick();
    e = q.pop_front();
    n_cmp++;
    if ({S, busy, iter_left, err} !== {e.s, e.busy, e.it, e.err}) begin
      n_bad++;
      $display("FAIL %s @%0d: S=%b busy=%b iter=%0d err=%b, expected S=%b busy=%b iter=%0d err=%b",
               tag, cyc, S, busy, iter_left, err, e.s, e.busy, e.it, e.err);
    end
  endtask
  // full run from IDLE to DONE; pert adds a 3-cycle stall at S=0101 and start pulses mid-run
  task automatic run(input logic [3:0] n, input int eff, input bit pert);
    tag = "load";
    step(mk(0, 1, n, 0, 0, 4'h1, 1, 4'(eff), 0));
    for (int p = eff; p >= 1; p--)
      for (int b = 2; b <= 10; b++) begin
        tag = "body";
        step(mk(0, pert && b == 6, n, 0, 0, 4'(b), 1, 4'(p), 0));
        if (pert && p == eff && b == 5)
          for (int k = 0; k < 3; k++) begin
            tag = "stall";
            step(mk(0, 0, n, 1, 0, 4'h5, 1, 4'(p), 0));
          end
      end
    tag = "fin1"; step(mk(0, 0, n, 0, 0, 4'hE, 1, 0, 0));
    tag = "fin2"; step(mk(0, 0, n, 0, 0, 4'hF, 1, 0, 0));
    tag = "done"; step(mk(0, 0, n, 0, 0, 4'hB, 1, 0, 0));
    tag = "hold"; step(mk(0, 1, n, 0, 0, 4'hB, 1, 0, 0));
    cmp("latency", t_done - t_load, 9 * eff + 3 + (pert ? 3 : 0));
  endtask
  task automatic ack();
    tag = "ack";
    step(mk(0, 0, 0, 0, 1, 4'h0, 0, 0, 0));
  endtask
  initial begin
    tbl[0] = mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    tbl[1] = mk(1, 1, 5, 0, 0, 4'h0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 1, 0, 4'h0, 0, 0, 0);
    tbl[3] = mk(0, 0, 0, 0, 1, 4'h0, 0, 0, 0);
    tbl[4] = mk(0, 0, 0, 1, 0, 4'hB, 1, 0, 0);
    tbl[5] = mk(0, 1, 2, 0, 1, 4'h0, 0, 0, 0);
    tbl[6] = mk(0, 1, 2, 0, 0, 4'h1, 1, 2, 0);
    tbl[7] = mk(0, 0, 2, 1, 0, 4'h1, 1, 2, 0);
    tbl[8] = mk(0, 0, 2, 0, 0, 4'h2, 1, 2, 0);
    tbl[9] = mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tag = $sformatf("tbl%0d", i);
      step(tbl[i]);
    end
    run(4'd1, 1, 1'b0); ack();
    run(4'd3, 3, 1'b0); ack();
    run(4'd0, 1, 1'b0); ack();
    run(4'd9, 9, 1'b0);
    cmp("clamp_iter", int'(it2_load), 2);
    cmp("clamp_latency", t2_done - t2_load, 21);
    ack();
    run(4'd2, 2, 1'b1);
    for (int i = 4; i < 10; i++) begin
      tag = $sformatf("tbl%0d", i);
      step(tbl[i]);
    end
    tag = "f_load"; step(mk(0, 1, 3, 0, 0, 4'h1, 1, 3, 0));
    tag = "f_body"; step(mk(0, 0, 3, 0, 0, 4'h2, 1, 3, 0));
    force dut.r_s = 4'hD;
    tick();
    release dut.r_s;
    cmp("illegal_err", int'(err), 1);
    cmp("illegal_iter", int'(iter_left), 0);
    tag = "illegal_idle"; step(mk(0, 0, 3, 0, 0, 4'h0, 0, 0, 1));
    tag = "err_clear";    step(mk(0, 1, 1, 0, 0, 4'h1, 1, 1, 0));
    for (int b = 2; b <= 6; b++) begin
      tag = "r_body";
      step(mk(0, 0, 1, 0, 0, 4'(b), 1, 1, 0));
    end
    tag = "rst_mid"; step(mk(1, 0, 1, 1, 0, 4'h0, 0, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/control_state_seq.md
Name: control_state_seq

Overview:
- Sequencer FSM that generates the 4-bit state code S[3:0] consumed by the datapath's control-output decoder.
- It drives the full datapath schedule: input load, a repeated arithmetic body, a finish pair, and a done state that holds until acknowledged.
- Output S is a registered one-hot-free binary code and changes only on rising clk.

Parameters:
- ITER_W, 4, width of the iteration-count input and counter.
- MAX_ITER, 15, upper clamp applied to n_iter at capture (must be at most 2^ITER_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin a run; sampled only in IDLE.
- n_iter  in  ITER_W  body iteration count; captured on start acceptance.
- stall  in  1  freeze request; holds S and the counter in LOAD/BODY/FIN states.
- done_ack  in  1  releases DONE back to IDLE.
- S  out  4  state code to the control-output decoder.
- busy  out  1  high in every state except IDLE.
- iter_left  out  ITER_W  remaining body passes, including the current one.
- err  out  1  sticky illegal-state flag; cleared on the next accepted start or on rst.

Behaviour:
- Reset is synchronous, active-high, and takes effect on the clk edge with rst=1 from any state, including mid-run. After reset: S=4'b0000, busy=0, iter_left=0, err=0.
- State codes:
  - IDLE=0000
  - LOAD=0001
  - BODY=0010..1010, nine steps in ascending order
  - FIN1=1110, FIN2=1111
  - DONE=1011
  - Illegal: 1100, 1101
- IDLE: stays while start=0. When start=1, the next S is LOAD, busy goes to 1, err is cleared, and iter_left is loaded with n_iter clamped to the range 1..MAX_ITER (n_iter=0 is treated as 1).
- LOAD goes to 0010. BODY steps advance by +1 each cycle from 0010 to 1010.
- At 1010:
  - If iter_left>1: next S is 0010 and iter_left decrements in the same edge.
  - If iter_left==1: next S is 1110, and iter_left becomes 0.
- FIN1 goes to FIN2, and FIN2 goes to DONE.
- DONE holds S=1011 until done_ack=1, then goes to IDLE. If done_ack and start are both high in DONE, the FSM goes to IDLE and start is not accepted that cycle.
- stall=1 in LOAD, BODY, FIN1 or FIN2 holds S and iter_left unchanged. stall is ignored in IDLE and DONE. stall has no effect on rst.
- start while busy is ignored and has no side effects.
- If S is ever 1100 or 1101 (forced or upset): next S is IDLE, err is set to 1, and iter_left is set to 0.
- Latency: the start edge gives S=LOAD on the next cycle. Unstalled cycles from LOAD to first DONE = 1 + 9*N + 2, where N is the clamped iteration count.
- All outputs are registered or derived only from registered state. No combinational path from any input to any output.

Optional Feature:
- Macro: CTRL_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and input step_mode (1 bit).
  - When step_mode=1, LOAD/BODY/FIN states advance only on a cycle where step=1 and stall=0. Otherwise they hold.
  - IDLE and DONE transitions are unaffected.
  - When step_mode=0, behaviour is identical to the macro-undefined build.
- When undefined: the step and step_mode ports do not exist, and the FSM advances every unstalled cycle.

Test Plan:
1. rst=1 for 2 cycles, then start=1 with n_iter=1 for one cycle -> S sequence 0001, 0010..1010, 1110, 1111, 1011. Exactly 12 cycles from LOAD to DONE. busy=1 throughout. S holds 1011 until done_ack=1, then 0000 with busy=0.
2. n_iter=3 -> BODY 0010..1010 repeats 3 times. iter_left reads 3, 2, 1 on successive passes, then 0 at FIN1. DONE reached 30 cycles after LOAD.
3. n_iter=0 -> runs exactly as n_iter=1. With MAX_ITER=2 and n_iter=9, exactly 2 passes.
4. stall=1 for 3 cycles while S=0101 -> S stays 0101 and iter_left is unchanged. The run completes 3 cycles later than the unstalled run. start pulsed mid-run -> no effect.
5. Force S=1101 -> next cycle S=0000, err=1. A subsequent start clears err. rst asserted while S=0110 -> next S=0000, busy=0.
6. In DONE, done_ack=1 and start=1 together -> S=0000, start not accepted. start in the following cycle -> S=0001.
